// File: rtl/pam_modulation_pkg.sv
// PAM framer shared types and elaboration helpers.
// Holds the FSM encoding and the symbol-to-level math.
package pam_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PILOT,
        S_DATA,
        S_GUARD
    } pam_state_e;

    // Counter width for a range of n values; never below one bit.
    function automatic int clog2_1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // DAC value for symbol k.
    function automatic int pam_level(
        input int k,
        input int lmin,
        input int step
    );
        return lmin + k * step;
    endfunction

    // True when all n levels fit a signed sample of the given width.
    function automatic bit levels_fit(
        input int n,
        input int lmin,
        input int step,
        input int width
    );
        int lo;
        int hi;
        int v;
        bit ok;
        lo = -(1 << (width - 1));
        hi = (1 << (width - 1)) - 1;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            v = pam_level(k, lmin, step);
            if (v < lo || v > hi) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pam_modulation_if.sv
// AXI-Stream word channel feeding the PAM framer.
// master drives data, slave returns tready.
interface pam_modulation_if #(
    parameter int WIDTH_AXI_DATA = 32
);
    logic                      tvalid;
    logic [WIDTH_AXI_DATA-1:0] tdata;
    logic                      tlast;
    logic                      tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/pam_modulation_level_map.sv
// Registered symbol to DAC level lookup.
// Table is built at elaboration; idle slots output zero.
module pam_level_map
    import pam_pkg::*;
#(
    parameter int AD_CVER_WIDTH = 12,
    parameter int PAM_ORDER     = 4,
    parameter int LEVEL_MIN     = -1920,
    parameter int LEVEL_STEP    = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [PAM_ORDER-1:0]            sym,
    output logic signed [AD_CVER_WIDTH-1:0] level
);
    localparam int N = 1 << PAM_ORDER;

    logic signed [AD_CVER_WIDTH-1:0] lut [N];

    for (genvar k = 0; k < N; k++) begin : g_lut
        assign lut[k] = AD_CVER_WIDTH'(
            pam_level(k, LEVEL_MIN, LEVEL_STEP));
    end

    if (!levels_fit(N, LEVEL_MIN, LEVEL_STEP,
                    AD_CVER_WIDTH)) begin : g_range_err
        $error("pam_level_map: level outside DAC range");
    end

    // Register the looked-up level, or zero outside pilot/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level <= '0;
        else if (en) level <= lut[sym];
        else level <= '0;
    end

endmodule

// File: rtl/pam_modulation.sv
// PAM TX framer: pilot ramp, data symbols, guard gap.
// Pulls packed words from AXI-Stream, emits DAC samples.
module pam_modulation
    import pam_pkg::*;
#(
    parameter int AD_CVER_WIDTH  = 12,
    parameter int LENGTH_DATA    = 1024,
    parameter int PAM_ORDER      = 4,
    parameter int WIDTH_AXI_DATA = 32,
    parameter int LEVEL_MIN      = -1920,
    parameter int LEVEL_STEP     = 256,
    parameter int GUARD_LEN      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    pam_modulation_if.slave                 s_axi,
    output logic signed [AD_CVER_WIDTH-1:0] dac_data,
    output logic                            dac_valid,
    output logic                            frame_start,
    output logic                            frame_done,
    output logic                            err_underflow,
    output logic                            err_tlast
);
    localparam int SYMS    = WIDTH_AXI_DATA / PAM_ORDER;
    localparam int N_PILOT = 1 << PAM_ORDER;
    localparam int WORDS   = LENGTH_DATA / SYMS;
    localparam int SW      = clog2_1(SYMS);
    localparam int WW      = clog2_1(WORDS);
    localparam int GW      = clog2_1(GUARD_LEN);
    localparam int GL_INT  = (GUARD_LEN > 0) ? GUARD_LEN - 1 : 0;

    localparam logic [PAM_ORDER-1:0] PILOT_LAST =
        PAM_ORDER'(N_PILOT - 1);
    localparam logic [SW-1:0] SYM_LAST   = SW'(SYMS - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GL_INT);

    if (WIDTH_AXI_DATA % PAM_ORDER != 0) begin : g_err_w
        $error("pam_modulation: PAM_ORDER must divide width");
    end

    if (WORDS < 1 || LENGTH_DATA % SYMS != 0) begin : g_err_len
        $error("pam_modulation: bad LENGTH_DATA");
    end

    pam_state_e state, state_nx;

    logic [PAM_ORDER-1:0] pilot_cnt, pilot_nx;
    logic [SW-1:0]        sym_idx, sym_nx;
    logic [WW-1:0]        word_cnt, word_nx;
    logic [GW-1:0]        guard_cnt, guard_nx;

    logic [SYMS-1:0][PAM_ORDER-1:0] word_buf, buf_nx;

    logic                 fetch;
    logic                 fetch_last;
    logic                 last_data;
    logic                 start_nx;
    logic                 unf_nx;
    logic                 tl_nx;
    logic                 sym_en;
    logic [PAM_ORDER-1:0] sym;
    logic [PAM_ORDER-1:0] cur_sym;

    // Symbol 0 of a word sits in the most significant slot.
    assign cur_sym = word_buf[SYM_LAST - sym_idx];

    assign s_axi.tready = fetch;

    // Next-state, counters, word fetch and pulse decode.
    always_comb begin
        state_nx   = state;
        pilot_nx   = pilot_cnt;
        sym_nx     = sym_idx;
        word_nx    = word_cnt;
        guard_nx   = guard_cnt;
        buf_nx     = word_buf;
        fetch      = 1'b0;
        fetch_last = 1'b0;
        last_data  = 1'b0;
        start_nx   = 1'b0;
        sym_en     = 1'b0;
        sym        = '0;
        unique case (state)
            S_IDLE: begin
                if (enable && s_axi.tvalid) state_nx = S_PILOT;
            end
            S_PILOT: begin
                sym      = pilot_cnt;
                sym_en   = 1'b1;
                start_nx = (pilot_cnt == '0);
                if (pilot_cnt == PILOT_LAST) begin
                    fetch      = 1'b1;
                    fetch_last = (WORDS == 1);
                    pilot_nx   = '0;
                    state_nx   = S_DATA;
                end else begin
                    pilot_nx = pilot_cnt + 1'b1;
                end
            end
            S_DATA: begin
                sym    = cur_sym;
                sym_en = 1'b1;
                if (sym_idx == SYM_LAST) begin
                    sym_nx = '0;
                    if (word_cnt == WORD_LAST) begin
                        last_data = 1'b1;
                        word_nx   = '0;
                        state_nx  = (GUARD_LEN == 0) ?
                                    S_IDLE : S_GUARD;
                    end else begin
                        fetch      = 1'b1;
                        fetch_last =
                            (int'(word_cnt) + 1 == WORDS - 1);
                        word_nx    = word_cnt + 1'b1;
                    end
                end else begin
                    sym_nx = sym_idx + 1'b1;
                end
            end
            S_GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    guard_nx = '0;
                    state_nx = S_IDLE;
                end else begin
                    guard_nx = guard_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (fetch) begin
            if (s_axi.tvalid) buf_nx = s_axi.tdata;
            else buf_nx = '0;
        end
        unf_nx = fetch && !s_axi.tvalid;
        tl_nx  = fetch && s_axi.tvalid &&
                 (s_axi.tlast != fetch_last);
    end

    // FSM state, counters and the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pilot_cnt <= '0;
            sym_idx   <= '0;
            word_cnt  <= '0;
            guard_cnt <= '0;
            word_buf  <= '0;
        end else begin
            state     <= state_nx;
            pilot_cnt <= pilot_nx;
            sym_idx   <= sym_nx;
            word_cnt  <= word_nx;
            guard_cnt <= guard_nx;
            word_buf  <= buf_nx;
        end
    end

    // Register the 1-bit outputs alongside the DAC sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_valid     <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            err_underflow <= 1'b0;
            err_tlast     <= 1'b0;
        end else begin
            dac_valid     <= sym_en;
            frame_start   <= start_nx;
            frame_done    <= last_data;
            err_underflow <= unf_nx;
            err_tlast     <= tl_nx;
        end
    end

    pam_level_map #(
        .AD_CVER_WIDTH (AD_CVER_WIDTH),
        .PAM_ORDER     (PAM_ORDER),
        .LEVEL_MIN     (LEVEL_MIN),
        .LEVEL_STEP    (LEVEL_STEP)
    ) u_map (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sym_en),
        .sym   (sym),
        .level (dac_data)
    );

endmodule

// File: tb/tb_pam_modulation.sv
// Bench for pam_modulation: two configurations checked
// against a frame-level sample model built from the stimulus.
module tb_pam_modulation;

    typedef struct {
        bit          gap;
        logic [31:0] data;
        bit          last;
    } item_t;

    localparam int NP [2] = '{16, 4};
    localparam int LEN[2] = '{1024, 64};
    localparam int SY [2] = '{8, 16};
    localparam int PO [2] = '{4, 2};
    localparam int LMN[2] = '{-1920, -1536};
    localparam int LST[2] = '{256, 1024};

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    always #5 clk = ~clk;

    pam_modulation_if #(.WIDTH_AXI_DATA(32)) ifa ();
    pam_modulation_if #(.WIDTH_AXI_DATA(32)) ifb ();

    logic signed [11:0] dac_a, dac_b;
    logic val_a, fs_a, fd_a, uf_a, tl_a;
    logic val_b, fs_b, fd_b, uf_b, tl_b;

    logic        tv[2];
    logic [31:0] td[2];
    logic        tlst[2];

    assign ifa.tvalid = tv[0];
    assign ifa.tdata  = td[0];
    assign ifa.tlast  = tlst[0];
    assign ifb.tvalid = tv[1];
    assign ifb.tdata  = td[1];
    assign ifb.tlast  = tlst[1];

    pam_modulation u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .s_axi         (ifa.slave),
        .dac_data      (dac_a),
        .dac_valid     (val_a),
        .frame_start   (fs_a),
        .frame_done    (fd_a),
        .err_underflow (uf_a),
        .err_tlast     (tl_a)
    );

    pam_modulation #(
        .AD_CVER_WIDTH  (12),
        .LENGTH_DATA    (64),
        .PAM_ORDER      (2),
        .WIDTH_AXI_DATA (32),
        .LEVEL_MIN      (-1536),
        .LEVEL_STEP     (1024),
        .GUARD_LEN      (0)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .s_axi         (ifb.slave),
        .dac_data      (dac_b),
        .dac_valid     (val_b),
        .frame_start   (fs_b),
        .frame_done    (fd_b),
        .err_underflow (uf_b),
        .err_tlast     (tl_b)
    );

    item_t fifo[2][$];
    int    expq[2][$];
    bit    pend[2];
    int    run[2], gapc[2], last_gap[2], frames[2];
    int    uf_cnt[2], tl_cnt[2], exp_uf[2], exp_tl[2];
    bit    had[2];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input int got,
                       input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lvl(input int i, input int k);
        return LMN[i] + k * LST[i];
    endfunction

    // mode 0: fixed 0x01234567, 1: gap at word 5,
    // 2: tlast on word 99 only, 3: plain random.
    task automatic add_frame(input int i, input int mode);
        int    words;
        int    s;
        item_t it;
        words = LEN[i] / SY[i];
        for (int k = 0; k < NP[i]; k++)
            expq[i].push_back(lvl(i, k));
        for (int p = 0; p < words; p++) begin
            it.gap  = (mode == 1 && p == 5);
            it.data = (mode == 0) ? 32'h01234567 : $urandom;
            it.last = (mode == 2) ? (p == 99) : (p == words - 1);
            fifo[i].push_back(it);
            if (it.gap) exp_uf[i]++;
            else if (it.last != (p == words - 1)) exp_tl[i]++;
            for (int j = 0; j < SY[i]; j++) begin
                s = it.gap ? 0 :
                    int'((it.data >> (32 - (j + 1) * PO[i]))
                         & ((32'd1 << PO[i]) - 1));
                expq[i].push_back(lvl(i, s));
            end
        end
    endtask

    task automatic drv(input int i, input bit rdy);
        if (pend[i] && fifo[i].size() > 0)
            void'(fifo[i].pop_front());
        pend[i] = 1'b0;
        if (fifo[i].size() > 0) begin
            tv[i]   = !fifo[i][0].gap;
            td[i]   = fifo[i][0].gap ? 32'd0 : fifo[i][0].data;
            tlst[i] = fifo[i][0].gap ? 1'b0 : fifo[i][0].last;
            pend[i] = rdy;
        end else begin
            tv[i]   = 1'b0;
            td[i]   = 32'd0;
            tlst[i] = 1'b0;
        end
    endtask

    task automatic mon(input int i, input int d, input bit v,
                       input bit fs, input bit fd,
                       input bit uf, input bit tl);
        int e;
        if (uf) uf_cnt[i]++;
        if (tl) tl_cnt[i]++;
        if (v) begin
            if (run[i] == 0 && had[i]) last_gap[i] = gapc[i];
            chk($sformatf("start%0d", i), int'(fs),
                int'(run[i] == 0));
            chk($sformatf("done%0d", i), int'(fd),
                int'(run[i] == NP[i] + LEN[i] - 1));
            e = 99999;
            if (expq[i].size() > 0) e = expq[i].pop_front();
            chk($sformatf("sample%0d_%0d", i, run[i]), d, e);
            run[i]++;
            gapc[i] = 0;
        end else begin
            chk($sformatf("idle_data%0d", i), d, 0);
            if (run[i] > 0) begin
                chk($sformatf("run_len%0d", i), run[i],
                    NP[i] + LEN[i]);
                frames[i]++;
                had[i] = 1'b1;
            end
            run[i] = 0;
            gapc[i]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, int'(dac_a), val_a, fs_a, fd_a, uf_a, tl_a);
        mon(1, int'(dac_b), val_b, fs_b, fd_b, uf_b, tl_b);
        drv(0, ifa.tready);
        drv(1, ifb.tready);
    end

    task automatic wait_frames(input int i, input int n);
        int c;
        c = 0;
        while (frames[i] < n && c < 4000) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk($sformatf("frames%0d", i), frames[i], n);
    endtask

    task automatic wait_run(input int i, input int n);
        int c;
        c = 0;
        while (run[i] < n && c < 2000) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk($sformatf("run_reach%0d", i), int'(run[i] >= n), 1);
    endtask

    task automatic chk_errs(input int i, input string t);
        chk({t, "_uf"}, uf_cnt[i], exp_uf[i]);
        chk({t, "_tl"}, tl_cnt[i], exp_tl[i]);
        chk({t, "_left"}, expq[i].size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            tv[i] = 1'b0;
            td[i] = '0;
            tlst[i] = 1'b0;
        end
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dac_a", int'(dac_a), 0);
        chk("rst_val_a", int'(val_a), 0);
        chk("rst_fs_a", int'(fs_a), 0);
        chk("rst_fd_a", int'(fd_a), 0);
        chk("rst_uf_a", int'(uf_a), 0);
        chk("rst_tl_a", int'(tl_a), 0);
        chk("rst_rdy_a", int'(ifa.tready), 0);
        chk("rst_dac_b", int'(dac_b), 0);
        chk("rst_val_b", int'(val_b), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        add_frame(0, 0);
        wait_frames(0, 1);
        chk_errs(0, "t1");

        add_frame(0, 1);
        wait_frames(0, 2);
        chk_errs(0, "t2");

        add_frame(0, 2);
        wait_frames(0, 3);
        chk_errs(0, "t3");

        add_frame(0, 3);
        add_frame(0, 3);
        wait_frames(0, 5);
        chk("t4_gap17", last_gap[0], 17);
        chk_errs(0, "t4");

        add_frame(1, 3);
        add_frame(1, 3);
        add_frame(1, 3);
        wait_frames(1, 3);
        chk("b_gap1", last_gap[1], 1);
        chk_errs(1, "b");

        add_frame(0, 3);
        for (int k = 0; k < 4; k++) begin
            item_t it;
            it.gap  = 1'b0;
            it.data = $urandom;
            it.last = 1'b0;
            fifo[0].push_back(it);
        end
        wait_run(0, 4);
        enable = 1'b0;
        wait_frames(0, 6);
        repeat (60) @(posedge clk);
        #2;
        chk("t5_no_restart", frames[0], 6);
        chk("t5_idle_run", run[0], 0);
        chk_errs(0, "t5");
        fifo[0].delete();
        pend[0] = 1'b0;
        enable  = 1'b1;

        add_frame(0, 3);
        wait_run(0, 16 + 501);
        rst_n = 1'b0;
        #1;
        chk("arst_val", int'(val_a), 0);
        chk("arst_dac", int'(dac_a), 0);
        chk("arst_rdy", int'(ifa.tready), 0);
        fifo[0].delete();
        expq[0].delete();
        pend[0] = 1'b0;
        run[0]  = 0;
        had[0]  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("arst_idle", run[0], 0);
        chk("arst_frames", frames[0], 6);

        add_frame(0, 3);
        wait_frames(0, 7);
        chk("t6_left", expq[0].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
